// File: rtl/gcd_stein_rtl.sv
// Iterative binary (Stein) GCD engine: shifts and subtracts only, start/rdy handshake.
// Returns the unsigned GCD magnitude and the number of cycles the operation took.
module gcd_stein_rtl #(
   parameter int NBits     = 8,
   parameter bit SIGNED_IN = 1'b1,
   localparam int CW       = $clog2(4*NBits) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [NBits-1:0] xi,
   input  logic [NBits-1:0] yi,
   output logic [NBits-1:0] xo,
   output logic             rdy,
   output logic             busy,
   output logic [CW-1:0]    cycles
);

   localparam int KW = $clog2(NBits) + 1;

   typedef enum logic [1:0] {IDLE, ABS, COMMON, REDUCE} state_t;

   state_t           state, state_nxt;
   logic [NBits-1:0] a, a_nxt, b, b_nxt;
   logic [KW-1:0]    k, k_nxt;
   logic [CW-1:0]    cnt, cnt_nxt, cnt_inc;
   logic [NBits-1:0] xo_nxt;
   logic             rdy_nxt, busy_nxt;
   logic [CW-1:0]    cycles_nxt;
   logic [NBits-1:0] abs_a, abs_b;

   // Negating the most negative value wraps to 2^(NBits-1), which is its true magnitude.
   assign abs_a   = (SIGNED_IN && a[NBits-1]) ? -a : a;
   assign abs_b   = (SIGNED_IN && b[NBits-1]) ? -b : b;
   assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;

   always_comb begin
      state_nxt  = state;
      a_nxt      = a;
      b_nxt      = b;
      k_nxt      = k;
      cnt_nxt    = cnt;
      xo_nxt     = xo;
      rdy_nxt    = 1'b0;
      busy_nxt   = busy;
      cycles_nxt = cycles;
      case (state)
         IDLE: begin
            if (start) begin
               a_nxt     = xi;
               b_nxt     = yi;
               cnt_nxt   = '0;
               busy_nxt  = 1'b1;
               state_nxt = ABS;
            end
         end
         ABS: begin
            a_nxt   = abs_a;
            b_nxt   = abs_b;
            k_nxt   = '0;
            cnt_nxt = cnt_inc;
            if (abs_a == '0 || abs_b == '0) begin
               xo_nxt     = abs_a | abs_b;
               rdy_nxt    = 1'b1;
               busy_nxt   = 1'b0;
               cycles_nxt = cnt_inc;
               state_nxt  = IDLE;
            end else begin
               state_nxt = COMMON;
            end
         end
         COMMON: begin
            cnt_nxt = cnt_inc;
            if (!a[0] && !b[0]) begin
               a_nxt = a >> 1;
               b_nxt = b >> 1;
               k_nxt = k + 1'b1;
            end else begin
               state_nxt = REDUCE;
            end
         end
         REDUCE: begin
            cnt_nxt = cnt_inc;
            if (a == b) begin
               xo_nxt     = a << k;
               rdy_nxt    = 1'b1;
               busy_nxt   = 1'b0;
               cycles_nxt = cnt_inc;
               state_nxt  = IDLE;
            end else if (!a[0]) begin
               a_nxt = a >> 1;
            end else if (!b[0]) begin
               b_nxt = b >> 1;
            end else if (a > b) begin
               a_nxt = (a - b) >> 1;
            end else begin
               b_nxt = (b - a) >> 1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         a      <= '0;
         b      <= '0;
         k      <= '0;
         cnt    <= '0;
         xo     <= '0;
         rdy    <= 1'b0;
         busy   <= 1'b0;
         cycles <= '0;
      end else begin
         state  <= state_nxt;
         a      <= a_nxt;
         b      <= b_nxt;
         k      <= k_nxt;
         cnt    <= cnt_nxt;
         xo     <= xo_nxt;
         rdy    <= rdy_nxt;
         busy   <= busy_nxt;
         cycles <= cycles_nxt;
      end
   end

endmodule

// File: tb/tb_gcd_stein_rtl.sv
// Scoreboarded bench for gcd_stein_rtl: signed 8-bit, unsigned 8-bit and signed 16-bit instances.
module tb_gcd_stein_rtl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        st0 = 1'b0, st1 = 1'b0, st2 = 1'b0;
   logic [7:0]  x0 = '0, y0 = '0, x1 = '0, y1 = '0;
   logic [15:0] x2 = '0, y2 = '0;
   logic [7:0]  xo0, xo1;
   logic [15:0] xo2;
   logic        rdy0, rdy1, rdy2, busy0, busy1, busy2;
   logic [5:0]  cyc0, cyc1;
   logic [6:0]  cyc2;

   always #5 clk = ~clk;

   gcd_stein_rtl #(.NBits(8), .SIGNED_IN(1'b1)) u_s8 (
      .clk(clk), .rst(rst), .start(st0), .xi(x0), .yi(y0),
      .xo(xo0), .rdy(rdy0), .busy(busy0), .cycles(cyc0));
   gcd_stein_rtl #(.NBits(8), .SIGNED_IN(1'b0)) u_u8 (
      .clk(clk), .rst(rst), .start(st1), .xi(x1), .yi(y1),
      .xo(xo1), .rdy(rdy1), .busy(busy1), .cycles(cyc1));
   gcd_stein_rtl #(.NBits(16), .SIGNED_IN(1'b1)) u_s16 (
      .clk(clk), .rst(rst), .start(st2), .xi(x2), .yi(y2),
      .xo(xo2), .rdy(rdy2), .busy(busy2), .cycles(cyc2));

   typedef struct {int id; int g; int cyc;} exp_t;
   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic got(input int id, input int xo, input int cyc);
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL unexpected_rdy: dut %0d gave xo=%0d with nothing outstanding", id, xo);
      end else begin
         e = sb.pop_front();
         chk("rdy_dut_id", id, e.id);
         chk("xo", xo, e.g);
         chk("cycles", cyc, e.cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rdy0) got(0, int'(xo0), int'(cyc0));
      if (rdy1) got(1, int'(xo1), int'(cyc1));
      if (rdy2) got(2, int'(xo2), int'(cyc2));
   end

   function automatic int mag(input int v, input int n, input bit s);
      int m;
      m = v & ((1 << n) - 1);
      if (s && m[n-1]) return (1 << n) - m;
      return m;
   endfunction

   // Reference Stein run: counts ABS, each COMMON cycle, and each REDUCE action.
   task automatic ref_run(input int a_in, input int b_in, output int g, output int cyc);
      int a, b, k;
      a = a_in; b = b_in; k = 0; cyc = 1;
      if (a == 0 || b == 0) begin
         g = a | b;
         return;
      end
      while (a % 2 == 0 && b % 2 == 0) begin
         a = a / 2; b = b / 2; k++; cyc++;
      end
      cyc++;
      while (a != b) begin
         if (a % 2 == 0) a = a / 2;
         else if (b % 2 == 0) b = b / 2;
         else if (a > b) a = (a - b) / 2;
         else b = (b - a) / 2;
         cyc++;
      end
      cyc++;
      g = a << k;
   endtask

   task automatic push_exp(input int id, input int x, input int y, input int g_hand);
      exp_t e;
      int   n, g;
      bit   s;
      n = (id == 2) ? 16 : 8;
      s = (id != 1);
      ref_run(mag(x, n, s), mag(y, n, s), g, e.cyc);
      e.id = id;
      e.g  = (g_hand >= 0) ? g_hand : g;
      sb.push_back(e);
   endtask

   task automatic drive(input int id, input logic st, input int x, input int y);
      case (id)
         0: begin st0 = st; x0 = x[7:0]; y0 = y[7:0]; end
         1: begin st1 = st; x1 = x[7:0]; y1 = y[7:0]; end
         default: begin st2 = st; x2 = x[15:0]; y2 = y[15:0]; end
      endcase
   endtask

   task automatic issue(input int id, input int x, input int y);
      drive(id, 1'b1, x, y);
      @(posedge clk);
      #1 st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
   endtask

   task automatic wait_done();
      int t = 0;
      while (sb.size() != 0 && t < 300) begin
         @(posedge clk);
         t++;
      end
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL timeout: %0d results outstanding, expected 0", sb.size());
         sb.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int id, input int x, input int y, input int g_hand);
      push_exp(id, x, y, g_hand);
      issue(id, x, y);
      wait_done();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int t;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_xo", int'(xo0), 0);
      chk("reset_rdy", int'(rdy0), 0);
      chk("reset_busy", int'(busy0), 0);
      chk("reset_cycles", int'(cyc0), 0);

      // Basic operation with busy timing; expected cycle count is 6.
      push_exp(0, 12, 18, 6);
      chk("model_cycles_12_18", sb[0].cyc, 6);
      issue(0, 12, 18);
      chk("busy_after_start", int'(busy0), 1);
      wait_done();
      chk("busy_after_rdy", int'(busy0), 0);

      run(0, -48, 36, 12);
      run(0, -128, 64, 64);
      run(0, 0, 0, 0);
      run(0, 0, -7, 7);
      run(0, 5, 0, 5);
      run(1, 255, 170, 85);
      run(1, 17, 13, 1);
      run(1, 128, 0, 128);
      run(2, -32768, 16384, 16384);
      run(2, 30030, -6006, 6006);

      // start held high while inputs change mid-operation
      push_exp(0, 12, 18, 6);
      push_exp(0, 7, 7, 7);
      drive(0, 1'b1, 12, 18);
      @(posedge clk);
      #1 drive(0, 1'b1, 7, 7);
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!rdy0 && t < 100);
      @(posedge clk);
      #1 st0 = 1'b0;
      chk("busy_second_op", int'(busy0), 1);
      wait_done();

      // Reset mid-operation: aborted operation gives no rdy.
      issue(0, 12, 18);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("abort_xo", int'(xo0), 0);
      chk("abort_busy", int'(busy0), 0);
      chk("abort_cycles", int'(cyc0), 0);
      chk("abort_rdy", int'(rdy0), 0);
      repeat (20) @(posedge clk);
      #1;
      run(0, 12, 18, 6);

      for (int id = 0; id < 3; id++) begin
         for (int i = 0; i < 10; i++) begin
            int x, y;
            x = $urandom_range(0, (id == 2) ? 65535 : 255);
            y = (i < 3) ? x * (i + 1) : $urandom_range(0, (id == 2) ? 65535 : 255);
            run(id, x, y, -1);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
